// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access, with one transaction in flight.
// Define MEM_PORT_ARB_PERF_EN to add the perf_if_wait / perf_dm_wait stall-cycle counters.
module mem_port_arbiter #(
    parameter int ADDR_W        = 64,
    parameter int DATA_W        = 64,
    parameter int MAX_DATA_WINS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [31:0]         if_rdata,
    output logic                if_done,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_wstrb,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                dm_done,
    output logic                mem_valid,
    input  logic                mem_ready,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
`ifdef MEM_PORT_ARB_PERF_EN
    ,
    output logic [31:0]         perf_if_wait,
    output logic [31:0]         perf_dm_wait
`endif
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(MAX_DATA_WINS + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(MAX_DATA_WINS);
    localparam logic [ADDR_W-1:0] WORD_MASK = ~(ADDR_W'(64'd7));

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef enum logic {
        OWN_DATA = 1'b0,
        OWN_IF   = 1'b1
    } owner_t;

    state_t           state_r;
    state_t           state_next_s;
    owner_t           owner_r;
    logic [CNT_W-1:0] starve_cnt_r;
    logic             if_hi_r;
    logic             grant_if_s;
    logic             grant_dm_s;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Arbitration and next-state decode; data wins ties until fetch has waited MAX_DATA_WINS grants
    always_comb begin
        state_next_s = state_r;
        grant_if_s   = 1'b0;
        grant_dm_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (if_req && (!dm_req || (starve_cnt_r == CNT_MAX))) begin
                    grant_if_s = 1'b1;
                end else if (dm_req) begin
                    grant_dm_s = 1'b1;
                end else begin
                    grant_if_s = 1'b0;
                end
                if (grant_if_s || grant_dm_s) begin
                    state_next_s = ST_REQ;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_ready) begin
                    state_next_s = ST_RESP;
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_RESP: begin
                if (mem_rvalid) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Fetch anti-starvation counter: counts data wins while fetch is waiting
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (grant_if_s) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (grant_dm_s && if_req && (starve_cnt_r != CNT_MAX)) begin
            starve_cnt_r <= starve_cnt_r + CNT_W'(1);
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    // Request payload latch, response capture and one-cycle completion strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_r   <= OWN_DATA;
            if_hi_r   <= 1'b0;
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= {ADDR_W{1'b0}};
            mem_wdata <= {DATA_W{1'b0}};
            mem_wstrb <= {STRB_W{1'b0}};
            if_done   <= 1'b0;
            dm_done   <= 1'b0;
            if_rdata  <= 32'h0000_0000;
            dm_rdata  <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_if_s) begin
                        owner_r   <= OWN_IF;
                        if_hi_r   <= if_addr[2];
                        mem_valid <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr & WORD_MASK;
                        mem_wdata <= {DATA_W{1'b0}};
                        mem_wstrb <= {STRB_W{1'b0}};
                    end else if (grant_dm_s) begin
                        owner_r   <= OWN_DATA;
                        mem_valid <= 1'b1;
                        mem_we    <= dm_we;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        mem_wstrb <= dm_wstrb;
                    end else begin
                        mem_valid <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                    end else begin
                        mem_valid <= 1'b1;
                    end
                end
                ST_RESP: begin
                    // Write acks also arrive as mem_rvalid; their data is simply passed along
                    if (mem_rvalid) begin
                        if (owner_r == OWN_IF) begin
                            if_done  <= 1'b1;
                            if_rdata <= if_hi_r ? mem_rdata[32 +: 32] : mem_rdata[0 +: 32];
                        end else begin
                            dm_done  <= 1'b1;
                            dm_rdata <= mem_rdata;
                        end
                    end else begin
                        if_done <= 1'b0;
                        dm_done <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if_done  <= 1'b0;
                    dm_done  <= 1'b0;
                    if_rdata <= 32'h0000_0000;
                    dm_rdata <= {DATA_W{1'b0}};
                end
                default: begin
                    mem_valid <= 1'b0;
                    if_done   <= 1'b0;
                    dm_done   <= 1'b0;
                end
            endcase
        end
    end

`ifdef MEM_PORT_ARB_PERF_EN
    // Stall-cycle counters: cycles a request is held without its completion pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_if_wait <= 32'd0;
            perf_dm_wait <= 32'd0;
        end else begin
            if (if_req && !if_done) begin
                perf_if_wait <= perf_if_wait + 32'd1;
            end else begin
                perf_if_wait <= perf_if_wait;
            end
            if (dm_req && !dm_done) begin
                perf_dm_wait <= perf_dm_wait + 32'd1;
            end else begin
                perf_dm_wait <= perf_dm_wait;
            end
        end
    end
`endif

endmodule
